// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver for the Basys 3 board.
// Shows a 16-bit value as hex, latched once per frame, with optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV = CLK_HZ / REFRESH_HZ - 1;
    localparam int CW  = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_C = CW'(DIV);

    generate
        if (DIV < 1) begin : g_div_chk
            $error("seg7_scan_driver: CLK_HZ/REFRESH_HZ must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    dp_shadow_q, dp_shadow_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic          wrap;
    logic [3:0]    nib;
    logic          blank;
    logic          z3, z32, z321;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Refresh divider and digit index; the shadow only moves on the 3 -> 0 wrap.
    always_comb begin
        tick        = (cnt_q == DIV_C);
        wrap        = tick && (idx_q == 2'd3);
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        shadow_d    = wrap ? value : shadow_q;
        dp_shadow_d = wrap ? dp_in : dp_shadow_q;
    end

    always_comb begin
        case (idx_q)
            2'd0:    nib = shadow_q[3:0];
            2'd1:    nib = shadow_q[7:4];
            2'd2:    nib = shadow_q[11:8];
            default: nib = shadow_q[15:12];
        endcase
    end

    // A digit is a leading zero only if it and every digit to its left are zero.
    always_comb begin
        z3   = (shadow_q[15:12] == 4'h0);
        z32  = z3 && (shadow_q[11:8] == 4'h0);
        z321 = z32 && (shadow_q[7:4] == 4'h0);
        case (idx_q)
            2'd0:    blank = 1'b0;
            2'd1:    blank = blank_lz && z321;
            2'd2:    blank = blank_lz && z32;
            default: blank = blank_lz && z3;
        endcase
    end

    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? 7'b1111111 : hex7(nib);
        dp_d  = ~dp_shadow_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            shadow_q    <= 16'h0000;
            dp_shadow_q <= 4'b0000;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            dp_shadow_q <= dp_shadow_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Frame-level vector table for seg7_scan_driver at DIV=3 (4-cycle dwell, 16-cycle frame).
// Each record is driven during one frame and its expected display checked in the next.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan_driver #(.CLK_HZ(1000), .REFRESH_HZ(250)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     v_early;
        logic [15:0]     v_late;
        int              late_edge;
        logic [3:0]      dp_in;
        logic            blank;
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
    } vec_t;

    typedef struct {
        logic [11:0] out;
        int          f;
        int          n;
    } exp_t;

    localparam int NREC = 12;
    localparam logic [11:0] RST_OUT = {4'b1111, 7'b1111111, 1'b1};
    localparam logic [6:0]  BLK = 7'b1111111;

    vec_t tab[NREC];
    exp_t sbq[$];
    int   errs;
    int   checks;

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
        end
    endtask

    // Frame 0 after reset shows the cleared shadow; frame f>0 shows record f-1.
    task automatic run_table(input int nrec);
        exp_t       e;
        exp_t       g;
        int         d;
        logic [6:0] s;
        logic       p;
        for (int f = 0; f <= nrec; f++) begin
            for (int n = 1; n <= 16; n++) begin
                if (f < nrec) begin
                    value = (n >= tab[f].late_edge) ? tab[f].v_late : tab[f].v_early;
                    dp_in = tab[f].dp_in;
                end else begin
                    value = 16'hFFFF;
                    dp_in = 4'hF;
                end
                blank_lz = (f == 0) ? 1'b0 : tab[f-1].blank;
                d = (n - 1) / 4;
                if (f == 0) begin
                    s = 7'b1000000;
                    p = 1'b1;
                end else begin
                    s = tab[f-1].seg[d];
                    p = tab[f-1].dpn[d];
                end
                e.out = {~(4'b0001 << d), s, p};
                e.f = f;
                e.n = n;
                sbq.push_back(e);
                @(posedge clk);
                #1;
                g = sbq.pop_front();
                chk($sformatf("frame%0d_edge%0d", g.f, g.n), {an, seg, dp}, g.out);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1);
    end

    initial begin
        errs = 0;
        checks = 0;
        //          early     late      edge dp_in blank  seg {d3,d2,d1,d0}                                      dpn
        tab[0]  = '{16'h12AF, 16'h12AF, 17, 4'h0, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'hF};
        tab[1]  = '{16'h1111, 16'h1111, 17, 4'h0, 1'b0, {7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001}, 4'hF};
        tab[2]  = '{16'h1111, 16'h2222,  7, 4'h0, 1'b0, {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}, 4'hF};
        tab[3]  = '{16'h0005, 16'h0005, 17, 4'h0, 1'b1, {BLK, BLK, BLK, 7'b0010010}, 4'hF};
        tab[4]  = '{16'h0000, 16'h0000, 17, 4'h0, 1'b1, {BLK, BLK, BLK, 7'b1000000}, 4'hF};
        tab[5]  = '{16'h0000, 16'h0000, 17, 4'h0, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'hF};
        tab[6]  = '{16'h0000, 16'h0000, 17, 4'h4, 1'b1, {BLK, BLK, BLK, 7'b1000000}, 4'b1011};
        tab[7]  = '{16'h0805, 16'h0805, 17, 4'h0, 1'b1, {BLK, 7'b0000000, 7'b1000000, 7'b0010010}, 4'hF};
        tab[8]  = '{16'h3333, 16'h4444, 16, 4'h9, 1'b0, {7'b0011001, 7'b0011001, 7'b0011001, 7'b0011001}, 4'b0110};
        tab[9]  = '{16'h6789, 16'h6789, 17, 4'h0, 1'b1, {7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000}, 4'hF};
        tab[10] = '{16'hBCDE, 16'hBCDE, 17, 4'h0, 1'b0, {7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110}, 4'hF};
        tab[11] = '{16'h0030, 16'h0030, 17, 4'h0, 1'b1, {BLK, BLK, 7'b0110000, 7'b1000000}, 4'hF};

        rst = 1'b0;
        value = 16'h12AF;
        dp_in = 4'h0;
        blank_lz = 1'b0;
        #1 rst = 1'b1;
        #1 chk("async_reset_power_on", {an, seg, dp}, RST_OUT);
        @(negedge clk);
        @(negedge clk);
        chk("held_in_reset", {an, seg, dp}, RST_OUT);
        rst = 1'b0;
        #1 chk("released_before_edge", {an, seg, dp}, RST_OUT);
        run_table(NREC);

        // Reset in the middle of a frame, with a nonzero shadow and dp_shadow.
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_mid_frame", {an, seg, dp}, RST_OUT);
        @(negedge clk);
        @(negedge clk);
        chk("mid_reset_held", {an, seg, dp}, RST_OUT);
        rst = 1'b0;
        #1 chk("mid_reset_released", {an, seg, dp}, RST_OUT);
        run_table(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
